// File: rtl/debug_fetch_controller.sv
// Debug sequencer for the fetch stage: assembles UART bytes into instructions,
// writes them to instruction memory, then gates the pipeline enable.
module debug_fetch_controller #(
    parameter int PC_BITS = 11,
    parameter int INSTRUCTION_BITS = 32,
    parameter logic [INSTRUCTION_BITS-1:0] HALT_WORD = {INSTRUCTION_BITS{1'b1}}
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [7:0]                  i_rx_data,
    input  logic                        i_rx_done,
    input  logic                        i_halt,
    output logic                        o_enable,
    output logic                        o_write_inst_mem,
    output logic [PC_BITS-1:0]          o_inst_mem_addr,
    output logic [INSTRUCTION_BITS-1:0] o_inst_mem_data,
    output logic                        o_loaded,
    output logic                        o_overflow,
    output logic [2:0]                  o_state
);

    localparam int NB = INSTRUCTION_BITS / 8;
    localparam int BC_W = (NB > 1) ? $clog2(NB) : 1;
    localparam logic [BC_W-1:0] LAST = BC_W'(NB - 1);

    localparam logic [7:0] CMD_L = 8'h4C;
    localparam logic [7:0] CMD_C = 8'h43;
    localparam logic [7:0] CMD_S = 8'h53;
    localparam logic [7:0] CMD_N = 8'h4E;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        LOAD       = 3'd1,
        WRITE      = 3'd2,
        RUN        = 3'd3,
        STEP       = 3'd4,
        STEP_PULSE = 3'd5,
        DONE       = 3'd6
    } state_t;

    state_t                      state_q, state_d;
    logic [BC_W-1:0]             byte_q, byte_d;
    logic [PC_BITS-1:0]          addr_q, addr_d;
    logic [INSTRUCTION_BITS-1:0] asm_q, asm_d;
    logic [INSTRUCTION_BITS-1:0] data_q, data_d;
    logic [INSTRUCTION_BITS-1:0] word;
    logic                        loaded_q, loaded_d;
    logic                        ovf_q, ovf_d;
    logic                        en_q, wr_q;
    logic                        take_byte;
    logic                        start_load;

    always_comb begin
        state_d    = state_q;
        byte_d     = byte_q;
        addr_d     = addr_q;
        asm_d      = asm_q;
        data_d     = data_q;
        loaded_d   = loaded_q;
        ovf_d      = ovf_q;
        take_byte  = 1'b0;
        start_load = 1'b0;
        word       = asm_q;
        word[int'(byte_q)*8 +: 8] = i_rx_data;

        unique case (state_q)
            IDLE: begin
                if (i_rx_done) begin
                    if (i_rx_data == CMD_L) begin
                        start_load = 1'b1;
                    end else if (loaded_q && i_rx_data == CMD_C) begin
                        state_d = RUN;
                    end else if (loaded_q && i_rx_data == CMD_S) begin
                        state_d = STEP;
                    end
                end
            end
            LOAD: begin
                take_byte = i_rx_done;
            end
            WRITE: begin
                if (data_q == HALT_WORD) begin
                    state_d  = IDLE;
                    loaded_d = 1'b1;
                end else if (&addr_q) begin
                    state_d  = IDLE;
                    loaded_d = 1'b1;
                    ovf_d    = 1'b1;
                end else begin
                    // A byte arriving now already belongs to the next word
                    addr_d    = addr_q + 1'b1;
                    state_d   = LOAD;
                    take_byte = i_rx_done;
                end
            end
            RUN: begin
                if (i_halt) begin
                    state_d = DONE;
                end
            end
            STEP: begin
                if (i_halt) begin
                    state_d = DONE;
                end else if (i_rx_done && i_rx_data == CMD_N) begin
                    state_d = STEP_PULSE;
                end else if (i_rx_done && i_rx_data == CMD_C) begin
                    state_d = RUN;
                end
            end
            STEP_PULSE: begin
                state_d = i_halt ? DONE : STEP;
            end
            DONE: begin
                start_load = i_rx_done && (i_rx_data == CMD_L);
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (start_load) begin
            state_d  = LOAD;
            addr_d   = '0;
            byte_d   = '0;
            loaded_d = 1'b0;
            ovf_d    = 1'b0;
        end

        if (take_byte) begin
            if (byte_q == LAST) begin
                data_d  = word;
                byte_d  = '0;
                state_d = WRITE;
            end else begin
                asm_d  = word;
                byte_d = byte_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            byte_q   <= '0;
            addr_q   <= '0;
            asm_q    <= '0;
            data_q   <= '0;
            loaded_q <= 1'b0;
            ovf_q    <= 1'b0;
            en_q     <= 1'b0;
            wr_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            byte_q   <= byte_d;
            addr_q   <= addr_d;
            asm_q    <= asm_d;
            data_q   <= data_d;
            loaded_q <= loaded_d;
            ovf_q    <= ovf_d;
            // Strobes follow the state being entered so they align with it
            en_q     <= (state_d == RUN) || (state_d == STEP_PULSE);
            wr_q     <= (state_d == WRITE);
        end
    end

    assign o_enable         = en_q;
    assign o_write_inst_mem = wr_q;
    assign o_inst_mem_addr  = addr_q;
    assign o_inst_mem_data  = data_q;
    assign o_loaded         = loaded_q;
    assign o_overflow       = ovf_q;
    assign o_state          = state_q;

endmodule
